// File: rtl/regfile_sb.sv
// Multi-port register file with busy-bit scoreboard for the dual-issue datapath.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we1,
  input  logic                     we2,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [ADDR_W-1:0]        wa2,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [DATA_W-1:0]        wd2,
  input  logic                     iss1,
  input  logic                     iss2,
  input  logic [ADDR_W-1:0]        ia1,
  input  logic [ADDR_W-1:0]        ia2,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic                     wr_conflict,
  output logic [15:0]              wr_count
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] rdIdx [NUM_RD];
  logic [NREGS-1:0]  setVec;
  logic [NREGS-1:0]  clrVec;
  logic [NREGS-1:0]  busyNext;
  logic              sameAddrWrite;
  logic [CNT_W-1:0]  countNext;

  assign sameAddrWrite = we1 && we2 && (wa1 == wa2);
  // Port 2 is the younger instruction, so a same-address pair commits only once.
  assign countNext = wr_count + CNT_W'(we1) + CNT_W'(we2) - CNT_W'(sameAddrWrite);

  // Storage; the later non-blocking assignment lets port 2 win on address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (we1) regs[wa1] <= wd1;
      if (we2) regs[wa2] <= wd2;
    end
  end

  // Scoreboard set/clear decode; issue dominates a same-cycle writeback.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      setVec[r] = (iss1 && (ia1 == ADDR_W'(r))) || (iss2 && (ia2 == ADDR_W'(r)));
      clrVec[r] = (we1 && (wa1 == ADDR_W'(r))) || (we2 && (wa2 == ADDR_W'(r)));
    end
    busyNext = setVec | (busy_vec & ~clrVec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec    <= '0;
      wr_conflict <= 1'b0;
      wr_count    <= '0;
    end else begin
      busy_vec    <= busyNext;
      wr_conflict <= sameAddrWrite;
      wr_count    <= countNext;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rdIdx[i] = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = regs[rdIdx[i]];
      rd_busy[i] = busy_vec[rdIdx[i]];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wa1 == rdIdx[i])) rd_data[i*DATA_W +: DATA_W] = wd1;
      if (we2 && (wa2 == rdIdx[i])) rd_data[i*DATA_W +: DATA_W] = wd2;
      if (((we1 && (wa1 == rdIdx[i])) || (we2 && (wa2 == rdIdx[i]))) &&
          !((iss1 && (ia1 == rdIdx[i])) || (iss2 && (ia2 == rdIdx[i])))) begin
        rd_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule
